addsub_arbiter: RTL
===================

# addsub_arbiter

Round-robin arbiter and sequencer that shares one 32-bit add/subtract datapath (`MultifunctionAdderSubtractor32`) among `NREQ` requesters. Each requester presents operands and an operation over a valid/ready request channel and receives the registered result and the carry and overflow flags over a valid/ready response channel. The block sits between the requesting units and the single shared adder and owns all sequencing of that adder.

## Interface

**Parameters**
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand width; fixed at 32 by the shared datapath.

**Ports**
- `clock`, in, 1: the single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, `NREQ`: per-requester request valid.
- `req_ready`, out, `NREQ`: per-requester request accepted; one-hot or zero.
- `req_a`, in, `NREQ*WIDTH`: packed operand A; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_b`, in, `NREQ*WIDTH`: packed operand B, packed the same way.
- `req_sub`, in, `NREQ`: 1 = A−B, 0 = A+B.
- `resp_valid`, out, `NREQ`: per-requester response valid; one-hot or zero.
- `resp_ready`, in, `NREQ`: per-requester response accept.
- `resp_result`, out, `WIDTH`: registered result, shared by all requesters.
- `resp_carry`, out, 1: registered carry-out. For subtract, 1 means no borrow.
- `resp_overflow`, out, 1: registered signed-overflow flag.
- `resp_id`, out, `$clog2(NREQ)`: index of the requester that owns the current response.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation

**States:** IDLE, EXEC, RESP. `reset` forces IDLE.

**IDLE**
- The winner is the lowest index at or after `rr_ptr` (wrapping) with `req_valid` set.
- `req_ready[winner]` is driven combinationally; all other `req_ready` bits are 0.
- On handshake, latch `a`, `b`, `sub` and `id` into operand registers, then go to EXEC.
- If no `req_valid` bit is set, stay in IDLE.

**EXEC**
- The adder sees the latched operands.
- `resp_result`, `resp_carry` and `resp_overflow` are registered at the end of this cycle.
- Next state is RESP.

**RESP**
- `resp_valid[id]` = 1. Result, flags and `resp_id` are held stable.
- On `resp_ready[id]`:
  - `rr_ptr` ← `id`+1, wrapping from `NREQ`−1 to 0.
  - Next state is IDLE.
- `resp_ready` bits of non-owners are ignored.

**Arithmetic:** two's complement, `{carry, result} = A + (B ^ {32{sub}}) + sub`. Overflow is set when the effective operand signs match and the result sign differs.

**Boundary conditions**
- Multiple requesters valid at once: round-robin order from `rr_ptr`; no requester is starved.
- `req_valid` withdrawn before handshake: allowed, with no side effects.
- `req_valid` held during EXEC or RESP: `req_ready` stays 0, so the request waits.
- Response stall: RESP holds indefinitely with all outputs stable.
- Reset mid-operation: the in-flight transaction is dropped with no response; `rr_ptr` is set to 0.
- `rr_ptr` is updated only on response completion, never on request accept.

## Timing

- **Reset values:** `req_ready`=0, `resp_valid`=0, `resp_result`=0, `resp_carry`=0, `resp_overflow`=0, `resp_id`=0, `busy`=0, `rr_ptr`=0, state=IDLE.
- **Latency:** request handshake in cycle t gives EXEC in t+1 and `resp_valid` high from t+2.
- **Throughput:** with `resp_ready` held high, at most one operation per 3 cycles. The next accept is possible in the cycle after the response handshake.
- `req_ready` depends combinationally on `req_valid` and state.
- `resp_valid` is a registered state decode with no dependence on inputs.

## Structure

- **Package `addsub_arb_pkg`:**
  - state enum `arb_state_t {IDLE, EXEC, RESP}`
  - `ADDSUB_WIDTH` = 32
  - default `NREQ`
- **Sub-module `rr_pick`:** parameterised on `NREQ`. Inputs are the request vector and the pointer; outputs are the one-hot grant and the encoded index; purely combinational.
- The shared adder is a single instance of `MultifunctionAdderSubtractor32` driven only from the operand registers.

## Test plan

- **Add with overflow:** reset, then requester 0 sends A=0x7FFFFFFF, B=1, add → `resp_valid[0]` at t+2 with result=0x80000000, carry=0, overflow=1, `resp_id`=0.
- **Subtract, no borrow and borrow:**
  - requester 1 sends 5−3 → result=2, carry=1, overflow=0.
  - requester 1 sends 3−5 → result=0xFFFFFFFE, carry=0, overflow=0.
- **Add wrap:** 0xFFFFFFFF+1 → result=0, carry=1, overflow=0; also 0x80000000−1 → result=0x7FFFFFFF, carry=1, overflow=1.
- **Fairness:** all 4 requesters hold `req_valid` continuously → grant order 0,1,2,3,0 with no repeats before wrap.
- **Response stall:** hold `resp_ready`=0 for 10 cycles while requester 2 waits → outputs stable and `req_ready` stays 0; release → requester 2 is granted the next cycle.
- **Reset mid-operation:** assert `reset` during EXEC → no `resp_valid` and all outputs at reset values; the next request from requester 3 completes normally with `rr_ptr` starting from 0.

Source files
------------

// File: rtl/addsub_arb_pkg.sv
// Shared types and constants for the add/subtract arbiter.
// Imported by the arbiter top and its round-robin picker.
package addsub_arb_pkg;

  localparam int ADDSUB_WIDTH = 32;
  localparam int DEFAULT_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/MultifunctionAdderSubtractor32.sv
// Shared 32-bit two's-complement add/subtract datapath.
// Subtract inverts B and injects a carry-in, so carry=1 means no borrow.
module MultifunctionAdderSubtractor32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result,
  output logic        carry,
  output logic        overflow
);

  logic [31:0] b_eff;
  logic [32:0] full;

  always_comb begin
    b_eff    = b ^ {32{sub}};
    full     = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};
    result   = full[31:0];
    carry    = full[32];
    overflow = (a[31] == b_eff[31]) && (full[31] != a[31]);
  end

endmodule

// File: rtl/addsub_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping around.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  int  cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sequencer sharing one add/subtract datapath among NREQ requesters.
// One operation in flight: accept in IDLE, compute in EXEC, hold the response in RESP.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int WIDTH = ADDSUB_WIDTH,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_carry,
  output logic                  resp_overflow,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  arb_state_t       state;
  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [IDW-1:0]   op_id;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             accept;

  logic [WIDTH-1:0] sum;
  logic             sum_carry;
  logic             sum_ovf;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  // The adder only ever sees the operand registers, never the live request bus.
  MultifunctionAdderSubtractor32 u_adder (
    .a        (op_a),
    .b        (op_b),
    .sub      (op_sub),
    .result   (sum),
    .carry    (sum_carry),
    .overflow (sum_ovf)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = (state == IDLE) && (|grant);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      op_a          <= '0;
      op_b          <= '0;
      op_sub        <= 1'b0;
      op_id         <= '0;
      resp_valid    <= '0;
      resp_result   <= '0;
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
      resp_id       <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= req_a[win_idx*WIDTH +: WIDTH];
            op_b   <= req_b[win_idx*WIDTH +: WIDTH];
            op_sub <= req_sub[win_idx];
            op_id  <= win_idx;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_result   <= sum;
          resp_carry    <= sum_carry;
          resp_overflow <= sum_ovf;
          resp_id       <= op_id;
          resp_valid    <= NREQ'(1) << op_id;
          state         <= RESP;
        end
        RESP: begin
          // Pointer advances only when the owner takes its response.
          if (resp_ready[op_id]) begin
            rr_ptr     <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
